// File: rtl/bp_fe_parcel_buffer.sv
// bp_fe_parcel_buffer
//  Fetch-side parcel queue between the I$ data return and bp_fe_scan. Aligned
//  fetch blocks are split into 16-bit parcels, leading parcels in front of
//  fetch_pc_i are dropped, and the rest are queued in a circular store. The
//  scanner sees a head-aligned window of up to fetch_cinstr_p parcels and
//  retires parcels through yumi_i.
//
//  Optional feature macro: BP_FE_PARCEL_BUF_BYPASS_EN
//   defined   - a write into an empty buffer drives the window combinationally
//               in the same cycle and may be retired immediately by yumi_i.
//   undefined - window is driven from registered state only (1-cycle latency).
//
//  The drop offset is the halfword index of fetch_pc_i within its block. Reset
//  asserts asynchronously; release is synchronised, so the buffer stays idle
//  for two clocks after reset_n_i rises.
module bp_fe_parcel_buffer #(
   parameter int vaddr_width_p  = 39,
   parameter int fetch_cinstr_p = 2,
   parameter int depth_p        = 2*fetch_cinstr_p,
   parameter int fetch_ptr_p    = $clog2(fetch_cinstr_p+1)
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        redirect_v_i,
   input  logic [vaddr_width_p-1:0]    redirect_pc_i,
   input  logic                        fetch_v_i,
   input  logic [vaddr_width_p-1:0]    fetch_pc_i,
   input  logic [16*fetch_cinstr_p-1:0] fetch_data_i,
   output logic                        fetch_ready_o,
   output logic                        v_o,
   output logic [vaddr_width_p-1:0]    pc_o,
   output logic [16*fetch_cinstr_p-1:0] instr_o,
   output logic [fetch_ptr_p-1:0]      count_o,
   output logic [fetch_ptr_p-1:0]      partial_o,
   input  logic [fetch_ptr_p-1:0]      yumi_i
);

   localparam int ptr_w_lp = $clog2(depth_p);
   localparam int occ_w_lp = $clog2(depth_p+1);
   localparam int off_w_lp = $clog2(fetch_cinstr_p);

   logic [1:0]                 rst_sync_q;
   logic                       run_en;
   logic [15:0]                mem_q [depth_p];
   logic [15:0]                mem_d [depth_p];
   logic [ptr_w_lp-1:0]        head_q, head_d;
   logic [ptr_w_lp-1:0]        tail_q, tail_d;
   logic [occ_w_lp-1:0]        occ_q, occ_d;
   logic [vaddr_width_p-1:0]   head_pc_q, head_pc_d;

   logic                       wr_fire;
   logic [off_w_lp-1:0]        drop_off;
   logic [occ_w_lp-1:0]        wr_cnt;
   logic [16*fetch_cinstr_p-1:0] blk_shift;

   logic                       st_v;
   logic [fetch_ptr_p-1:0]     st_count;
   logic [16*fetch_cinstr_p-1:0] st_instr;

   logic                       byp_sel;
   logic                       byp_v;
   logic [fetch_ptr_p-1:0]     byp_count;

   // Reset release synchroniser: async clear, two-stage release.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) rst_sync_q <= 2'b00;
      else            rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign run_en = rst_sync_q[1];

   // Space check uses registered occupancy only; retires this cycle do not help.
   assign fetch_ready_o = (occ_q <= occ_w_lp'(depth_p - fetch_cinstr_p));
   assign wr_fire       = fetch_v_i & fetch_ready_o & ~redirect_v_i & run_en;
   assign drop_off      = fetch_pc_i[off_w_lp:1];
   assign wr_cnt        = occ_w_lp'(fetch_cinstr_p) - occ_w_lp'(drop_off);
   // Useful parcels moved down to lane 0; vacated upper lanes read as zero.
   assign blk_shift     = fetch_data_i >> {drop_off, 4'b0000};

   // Window from registered state.
   assign st_v     = (occ_q >= occ_w_lp'(fetch_cinstr_p));
   assign st_count = st_v ? fetch_ptr_p'(fetch_cinstr_p) : fetch_ptr_p'(occ_q);

   generate
      for (genvar gi = 0; gi < fetch_cinstr_p; gi++) begin : g_lane
         logic [ptr_w_lp-1:0] rd_idx;
         assign rd_idx = head_q + ptr_w_lp'(gi);
         assign st_instr[16*gi +: 16] =
            (fetch_ptr_p'(gi) < st_count) ? mem_q[rd_idx] : 16'h0000;
      end
   endgenerate

`ifdef BP_FE_PARCEL_BUF_BYPASS_EN
   assign byp_sel = wr_fire & (occ_q == '0);
`else
   assign byp_sel = 1'b0;
`endif
   assign byp_v     = (wr_cnt == occ_w_lp'(fetch_cinstr_p));
   assign byp_count = fetch_ptr_p'(wr_cnt);

   assign v_o       = byp_sel ? byp_v     : st_v;
   assign count_o   = byp_sel ? byp_count : st_count;
   assign instr_o   = byp_sel ? blk_shift : st_instr;
   assign pc_o      = byp_sel ? fetch_pc_i : head_pc_q;
   assign partial_o = v_o ? '0 : count_o;

   // Parcel store update: write useful parcels of an accepted block at tail.
   always_comb begin
      mem_d = mem_q;
      if (wr_fire) begin
         for (int k = 0; k < fetch_cinstr_p; k++) begin
            if (occ_w_lp'(k) < wr_cnt)
               mem_d[tail_q + ptr_w_lp'(k)] = blk_shift[16*k +: 16];
         end
      end
   end

   // Pointer / occupancy / head PC next state; redirect overrides everything.
   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      occ_d     = occ_q;
      head_pc_d = head_pc_q;
      if (redirect_v_i) begin
         head_d    = '0;
         tail_d    = '0;
         occ_d     = '0;
         head_pc_d = redirect_pc_i;
      end else begin
         if (wr_fire) tail_d = tail_q + ptr_w_lp'(wr_cnt);
         occ_d  = occ_q + (wr_fire ? wr_cnt : '0) - occ_w_lp'(yumi_i);
         head_d = head_q + ptr_w_lp'(yumi_i);
         // An empty buffer takes its head PC from the first block written.
         head_pc_d = ((wr_fire && occ_q == '0) ? fetch_pc_i : head_pc_q)
                     + (vaddr_width_p'(yumi_i) << 1);
      end
   end

   // Parcel storage; contents are qualified by occupancy, so no reset needed.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   // Control state, held at reset until the synchronised release.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         head_q    <= '0;
         tail_q    <= '0;
         occ_q     <= '0;
         head_pc_q <= '0;
      end else if (!run_en) begin
         head_q    <= '0;
         tail_q    <= '0;
         occ_q     <= '0;
         head_pc_q <= '0;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         occ_q     <= occ_d;
         head_pc_q <= head_pc_d;
      end
   end

`ifndef SYNTHESIS
   a_yumi_le_count: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (yumi_i <= count_o));
   a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (!v_o |-> (yumi_i == '0)));
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (({1'b0, occ_q} + (wr_fire ? {1'b0, wr_cnt} : '0)) <= (occ_w_lp+1)'(depth_p)));
`endif

endmodule
